// File: rtl/uii2c_pkg.sv
// Shared definitions for the uii2c master front-end arbiter: FSM encoding and
// the per-requester slice widths of the master's request fields.
package uii2c_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam int WR_DATA_W = 32;
   localparam int WR_CNT_W  = 8;
   localparam int RD_CNT_W  = 8;

endpackage

// File: rtl/uii2c_arb_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found by
// scanning upward from ptr, wrapping modulo NREQ.
module ui_rr_pick
   import uii2c_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic            hit,
   output logic [PW-1:0]   idx
);

   logic [NREQ-1:0] rot;
   logic [PW:0]     sum;

   // Rotate so bit 0 is the requester at ptr; the lowest set bit of rot wins.
   always_comb begin
      rot = NREQ'({req, req} >> ptr);
      hit = 1'b0;
      sum = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            hit = 1'b1;
            sum = {1'b0, ptr} + (PW + 1)'(i);
         end
      end
      if (sum >= (PW + 1)'(NREQ)) begin
         sum = sum - (PW + 1)'(NREQ);
      end
      idx = sum[PW-1:0];
   end

endmodule

// File: rtl/uii2c_arb.sv
// Round-robin arbiter that shares one uii2c master between NREQ requesters,
// latching the winner's transaction and running the iic_req/iic_busy handshake.
module uii2c_arb
   import uii2c_pkg::*;
#(
   parameter int          NREQ    = 2,
   parameter logic [15:0] TIMEOUT = 16'd4095
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NREQ-1:0]           req_i,
   input  logic [NREQ*WR_DATA_W-1:0] wr_data_i,
   input  logic [NREQ*WR_CNT_W-1:0]  wr_cnt_i,
   input  logic [NREQ*RD_CNT_W-1:0]  rd_cnt_i,
   input  logic [NREQ-1:0]           mode_i,
   output logic [NREQ-1:0]           grant_o,
   output logic [NREQ-1:0]           done_o,
   output logic [NREQ-1:0]           err_o,
   output logic [7:0]                rd_data_o,
   output logic                      m_req_o,
   output logic [WR_DATA_W-1:0]      m_wr_data_o,
   output logic [WR_CNT_W-1:0]       m_wr_cnt_o,
   output logic [RD_CNT_W-1:0]       m_rd_cnt_o,
   output logic                      m_mode_o,
   input  logic [7:0]                m_rd_data_i,
   input  logic                      m_busy_i
);

   localparam int              PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] GRANT_ONE = NREQ'(1);

   arb_state_t    state, state_n;
   logic [PW-1:0] ptr;
   logic [PW-1:0] own;
   logic [PW-1:0] own_next;
   logic [PW-1:0] pick_idx;
   logic          pick_hit;
   logic [15:0]   tmo_cnt;
   logic          settle;
   logic          do_grant;
   logic          do_timeout;

   ui_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req (req_i),
      .ptr (ptr),
      .hit (pick_hit),
      .idx (pick_idx)
   );

   // A completion/error pulse cycle is never a grant cycle, which gives the
   // finished requester one cycle to drop its request before re-arbitration.
   assign settle   = (|done_o) || (|err_o);
   assign own_next = (own == PW'(NREQ - 1)) ? '0 : own + PW'(1);

   always_comb begin
      state_n    = state;
      do_grant   = 1'b0;
      do_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (!m_busy_i && pick_hit && !settle) begin
               do_grant = 1'b1;
               state_n  = ISSUE;
            end
         end
         ISSUE: begin
            if (m_busy_i) begin
               state_n = WAIT;
            end else if (tmo_cnt == TIMEOUT) begin
               do_timeout = 1'b1;
               state_n    = IDLE;
            end
         end
         WAIT: begin
            if (!m_busy_i) begin
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Datapath: the master-side fields are frozen at grant so requesters may
   // change their inputs freely while their transaction is in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr         <= '0;
         own         <= '0;
         tmo_cnt     <= '0;
         grant_o     <= '0;
         done_o      <= '0;
         err_o       <= '0;
         rd_data_o   <= '0;
         m_req_o     <= 1'b0;
         m_wr_data_o <= '0;
         m_wr_cnt_o  <= '0;
         m_rd_cnt_o  <= '0;
         m_mode_o    <= 1'b0;
      end else begin
         done_o <= '0;
         err_o  <= '0;
         case (state)
            IDLE: begin
               if (do_grant) begin
                  grant_o     <= GRANT_ONE << pick_idx;
                  own         <= pick_idx;
                  m_wr_data_o <= wr_data_i[WR_DATA_W*int'(pick_idx) +: WR_DATA_W];
                  m_wr_cnt_o  <= wr_cnt_i[WR_CNT_W*int'(pick_idx) +: WR_CNT_W];
                  m_rd_cnt_o  <= rd_cnt_i[RD_CNT_W*int'(pick_idx) +: RD_CNT_W];
                  m_mode_o    <= mode_i[pick_idx];
                  m_req_o     <= 1'b1;
                  tmo_cnt     <= '0;
               end
            end
            ISSUE: begin
               if (m_busy_i) begin
                  m_req_o <= 1'b0;
               end else if (do_timeout) begin
                  err_o   <= grant_o;
                  m_req_o <= 1'b0;
                  grant_o <= '0;
                  ptr     <= own_next;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            WAIT: begin
               if (!m_busy_i) begin
                  rd_data_o <= m_rd_data_i;
               end
            end
            DONE: begin
               done_o  <= grant_o;
               grant_o <= '0;
               ptr     <= own_next;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uii2c_arb.sv
// Directed bench for uii2c_arb: two requesters, a hand-driven master busy line,
// and hand-computed expectations checked with immediate assertions.
module tb_uii2c_arb;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  req_i;
   logic [63:0] wr_data_i;
   logic [15:0] wr_cnt_i;
   logic [15:0] rd_cnt_i;
   logic [1:0]  mode_i;
   logic [1:0]  grant_o;
   logic [1:0]  done_o;
   logic [1:0]  err_o;
   logic [7:0]  rd_data_o;
   logic        m_req_o;
   logic [31:0] m_wr_data_o;
   logic [7:0]  m_wr_cnt_o;
   logic [7:0]  m_rd_cnt_o;
   logic        m_mode_o;
   logic [7:0]  m_rd_data_i;
   logic        m_busy_i;

   int vectors     = 0;
   int miscompares = 0;

   uii2c_arb #(
      .NREQ    (2),
      .TIMEOUT (16'd10)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_i),
      .wr_data_i   (wr_data_i),
      .wr_cnt_i    (wr_cnt_i),
      .rd_cnt_i    (rd_cnt_i),
      .mode_i      (mode_i),
      .grant_o     (grant_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .rd_data_o   (rd_data_o),
      .m_req_o     (m_req_o),
      .m_wr_data_o (m_wr_data_o),
      .m_wr_cnt_o  (m_wr_cnt_o),
      .m_rd_cnt_o  (m_rd_cnt_o),
      .m_mode_o    (m_mode_o),
      .m_rd_data_i (m_rd_data_i),
      .m_busy_i    (m_busy_i)
   );

   always #5 clk_i = ~clk_i;

   // Advance n clock edges and settle 1 ns past the last one.
   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] req, input logic [63:0] wd,
                                input logic [15:0] wc, input logic [15:0] rc,
                                input logic [1:0] mode);
      req_i     = req;
      wr_data_i = wd;
      wr_cnt_i  = wc;
      rd_cnt_i  = rc;
      mode_i    = mode;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
         $error("[TB] check %s differs", tag);
      end
   endtask

   // Entered in the cycle the grant is visible; leaves at the start of the
   // second cycle after done_o, with req_gap applied in between.
   task automatic serveOne(input string tag, input logic [1:0] exp_grant,
                           input logic [7:0] rd_byte, input logic [1:0] req_gap,
                           input logic [1:0] req_after);
      checkOutput({tag, ".grant"}, 32'(grant_o), 32'(exp_grant));
      checkOutput({tag, ".mreq"}, 32'(m_req_o), 32'd1);
      m_busy_i = 1'b1;
      waitCycles(1);
      checkOutput({tag, ".mreq_drop"}, 32'(m_req_o), 32'd0);
      m_busy_i    = 1'b0;
      m_rd_data_i = rd_byte;
      waitCycles(1);
      checkOutput({tag, ".done_early"}, 32'(done_o), 32'd0);
      waitCycles(1);
      checkOutput({tag, ".done"}, 32'(done_o), 32'(exp_grant));
      checkOutput({tag, ".rd_data"}, 32'(rd_data_o), 32'(rd_byte));
      checkOutput({tag, ".grant_clr"}, 32'(grant_o), 32'd0);
      waitCycles(1);
      req_i = req_gap;
      checkOutput({tag, ".done_once"}, 32'(done_o), 32'd0);
      waitCycles(1);
      req_i = req_after;
   endtask

   initial begin
      rst_i       = 1'b1;
      m_busy_i    = 1'b0;
      m_rd_data_i = 8'h00;
      applyStimulus(2'b00, 64'h0, 16'h0, 16'h0, 2'b00);
      waitCycles(2);
      rst_i = 1'b0;
      checkOutput("reset.grant", 32'(grant_o), 32'd0);
      checkOutput("reset.mreq", 32'(m_req_o), 32'd0);
      checkOutput("reset.done", 32'(done_o), 32'd0);
      checkOutput("reset.err", 32'(err_o), 32'd0);
      checkOutput("reset.rd_data", 32'(rd_data_o), 32'd0);
      checkOutput("reset.wr_data", m_wr_data_o, 32'd0);

      $display("[TB] single write");
      applyStimulus(2'b01, 64'h0000_0000_0A08_3078, 16'h0004, 16'h0000, 2'b00);
      waitCycles(1);
      checkOutput("wr.grant", 32'(grant_o), 32'h1);
      checkOutput("wr.mreq", 32'(m_req_o), 32'd1);
      checkOutput("wr.wr_data", m_wr_data_o, 32'h0A08_3078);
      checkOutput("wr.wr_cnt", 32'(m_wr_cnt_o), 32'd4);
      checkOutput("wr.mode", 32'(m_mode_o), 32'd0);
      wr_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
      waitCycles(2);
      checkOutput("wr.mreq_hold", 32'(m_req_o), 32'd1);
      m_busy_i = 1'b1;
      waitCycles(1);
      checkOutput("wr.mreq_drop", 32'(m_req_o), 32'd0);
      waitCycles(19);
      checkOutput("wr.busy_grant", 32'(grant_o), 32'h1);
      m_busy_i    = 1'b0;
      m_rd_data_i = 8'h11;
      waitCycles(2);
      checkOutput("wr.done", 32'(done_o), 32'h1);
      checkOutput("wr.err", 32'(err_o), 32'd0);
      checkOutput("wr.rd_data", 32'(rd_data_o), 32'h11);
      checkOutput("wr.latched", m_wr_data_o, 32'h0A08_3078);
      waitCycles(1);
      req_i = 2'b00;
      checkOutput("wr.done_once", 32'(done_o), 32'd0);
      waitCycles(2);
      checkOutput("wr.idle", 32'(grant_o), 32'd0);

      $display("[TB] simultaneous requests");
      rst_i = 1'b1;
      waitCycles(1);
      rst_i = 1'b0;
      applyStimulus(2'b11, 64'h2222_2222_1111_1111, 16'h0202, 16'h0000, 2'b00);
      waitCycles(1);
      serveOne("rr0", 2'b01, 8'hA0, 2'b10, 2'b11);
      serveOne("rr1", 2'b10, 8'hA1, 2'b01, 2'b11);
      serveOne("rr2", 2'b01, 8'hA2, 2'b10, 2'b11);
      serveOne("rr3", 2'b10, 8'hA3, 2'b00, 2'b00);
      checkOutput("rr.idle", 32'(grant_o), 32'd0);

      $display("[TB] read capture");
      applyStimulus(2'b10, 64'h0000_0021_0000_0000, 16'h0100, 16'h0100, 2'b10);
      waitCycles(1);
      checkOutput("rd.mode", 32'(m_mode_o), 32'd1);
      checkOutput("rd.rd_cnt", 32'(m_rd_cnt_o), 32'd1);
      checkOutput("rd.wr_data", m_wr_data_o, 32'h0000_0021);
      serveOne("rd", 2'b10, 8'h56, 2'b00, 2'b00);
      m_rd_data_i = 8'hEE;
      waitCycles(3);
      checkOutput("rd.held", 32'(rd_data_o), 32'h56);

      $display("[TB] timeout");
      applyStimulus(2'b11, 64'h0000_0000_1234_5678, 16'h0001, 16'h0000, 2'b00);
      waitCycles(1);
      checkOutput("to.grant", 32'(grant_o), 32'h1);
      checkOutput("to.mreq", 32'(m_req_o), 32'd1);
      waitCycles(10);
      checkOutput("to.err_early", 32'(err_o), 32'd0);
      checkOutput("to.mreq_hold", 32'(m_req_o), 32'd1);
      waitCycles(1);
      checkOutput("to.err", 32'(err_o), 32'h1);
      checkOutput("to.mreq_clr", 32'(m_req_o), 32'd0);
      checkOutput("to.grant_clr", 32'(grant_o), 32'd0);
      checkOutput("to.done", 32'(done_o), 32'd0);
      waitCycles(1);
      req_i = 2'b10;
      checkOutput("to.err_once", 32'(err_o), 32'd0);
      waitCycles(1);
      checkOutput("to.next_grant", 32'(grant_o), 32'h2);

      $display("[TB] reset mid-wait");
      m_busy_i = 1'b1;
      waitCycles(1);
      checkOutput("rst.in_wait", 32'(m_req_o), 32'd0);
      waitCycles(2);
      rst_i = 1'b1;
      waitCycles(1);
      rst_i = 1'b0;
      req_i = 2'b11;
      checkOutput("rst.grant", 32'(grant_o), 32'd0);
      checkOutput("rst.mreq", 32'(m_req_o), 32'd0);
      checkOutput("rst.done", 32'(done_o), 32'd0);
      checkOutput("rst.rd_data", 32'(rd_data_o), 32'd0);
      checkOutput("rst.wr_data", m_wr_data_o, 32'd0);
      waitCycles(3);
      checkOutput("rst.no_grant", 32'(grant_o), 32'd0);
      checkOutput("rst.no_done", 32'(done_o), 32'd0);
      m_busy_i = 1'b0;
      waitCycles(1);

      $display("[TB] request withdrawn after grant");
      checkOutput("wd.wr_data", m_wr_data_o, 32'h1234_5678);
      applyStimulus(2'b00, 64'hDEAD_BEEF_DEAD_BEEF, 16'h0000, 16'h0000, 2'b11);
      serveOne("wd", 2'b01, 8'h9C, 2'b00, 2'b00);
      checkOutput("wd.latched", m_wr_data_o, 32'h1234_5678);
      checkOutput("wd.idle", 32'(grant_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
